// File: rtl/la_pwrseq_pkg.sv
// Shared types and helpers for the la_pwrseq power-domain sequencer.
package la_pwrseq_pkg;

  // Sequencer states; 3-bit binary encoding.
  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_WAIT_GOOD = 3'd2,
    ST_DEISO     = 3'd3,
    ST_ON        = 3'd4,
    ST_ISO       = 3'd5,
    ST_RAMP_DOWN = 3'd6
  } state_e;

  // Smallest legal spacing between bank steps.
  localparam int unsigned MIN_SPACING = 32'd1;

  // Effective step spacing: a programmed delay of 0 still spaces banks one cycle apart.
  function automatic int unsigned eff_spacing(input int unsigned d);
    if (d < MIN_SPACING) begin
      return MIN_SPACING;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/la_pwrseq_sync.sv
// Two-flop synchronizer for the asynchronous domain power-good signal.
module la_pwrseq_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous input through two flops; both clear to 0 on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: staged switch-bank turn-on, power-good wait,
// isolation release and acknowledge; power-down runs the reverse order.
module la_pwrseq
  import la_pwrseq_pkg::*;
#(
  parameter int    N       = 4,
  parameter int    DW      = 8,
  parameter int    TW      = 12,
  parameter int    TIMEOUT = 1024,
  parameter string PROP    = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [DW-1:0] stagedelay,
  input  logic          pwr_good,
  output logic [N-1:0]  sw_en,
  output logic          iso_en,
  output logic          ack,
  output logic          busy,
  output logic          err
);

  localparam logic [N-1:0]  SW_FIRST = N'(1'b1);
  localparam logic [N-1:0]  SW_ALL   = '1;
  localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1'b1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1'b1);

  state_e        state_q;
  logic [N-1:0]  sw_q;
  logic          iso_q;
  logic          ack_q;
  logic          busy_q;
  logic          err_q;
  logic          armed_q;
  logic [DW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;

  logic          pg_s;
  logic [DW-1:0] spacing_s;
  logic          last_bank_s;

  la_pwrseq_sync u_pg_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (pwr_good),
    .q_o   (pg_s)
  );

  // Step spacing is re-sampled at every counter reload.
  assign spacing_s   = DW'(eff_spacing(32'(stagedelay)));
  // Only bank 0 is still conducting, so the next ramp-down step ends in OFF.
  assign last_bank_s = (sw_q == SW_FIRST);

  // Sequencer FSM with all outputs registered; sw_en stays a thermometer code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      sw_q    <= '0;
      iso_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (!req) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            sw_q    <= SW_FIRST;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= spacing_s;
            busy_q  <= 1'b1;
            state_q <= ST_RAMP_UP;
          end
        end

        ST_RAMP_UP: begin
          if (!req) begin
            sw_q  <= sw_q >> 1'b1;
            cnt_q <= spacing_s;
            if (last_bank_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_OFF;
            end else begin
              state_q <= ST_RAMP_DOWN;
            end
          end else if (cnt_q <= CNT_ONE) begin
            if (sw_q == SW_ALL) begin
              tmo_q   <= TMO_INIT;
              state_q <= ST_WAIT_GOOD;
            end else begin
              sw_q  <= (sw_q << 1'b1) | SW_FIRST;
              cnt_q <= spacing_s;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_WAIT_GOOD: begin
          if (!req || (!pg_s && (tmo_q <= TMO_ONE))) begin
            // Request drop and power-good timeout share the same unwind path.
            if (req) begin
              err_q <= 1'b1;
            end
            tmo_q <= '0;
            sw_q  <= sw_q >> 1'b1;
            cnt_q <= spacing_s;
            if (last_bank_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_OFF;
            end else begin
              state_q <= ST_RAMP_DOWN;
            end
          end else if (pg_s) begin
            iso_q   <= 1'b0;
            state_q <= ST_DEISO;
          end else begin
            tmo_q <= tmo_q - TMO_ONE;
          end
        end

        ST_DEISO: begin
          if (!req) begin
            iso_q   <= 1'b1;
            state_q <= ST_ISO;
          end else begin
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_ON;
          end
        end

        ST_ON: begin
          if (!req) begin
            iso_q   <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_ISO;
          end
        end

        ST_ISO: begin
          sw_q  <= sw_q >> 1'b1;
          cnt_q <= spacing_s;
          if (last_bank_s) begin
            busy_q  <= 1'b0;
            state_q <= ST_OFF;
          end else begin
            state_q <= ST_RAMP_DOWN;
          end
        end

        ST_RAMP_DOWN: begin
          if (cnt_q <= CNT_ONE) begin
            sw_q  <= sw_q >> 1'b1;
            cnt_q <= spacing_s;
            if (last_bank_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_OFF;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= ST_OFF;
          sw_q    <= '0;
          iso_q   <= 1'b1;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          tmo_q   <= '0;
        end
      endcase
    end
  end

  assign sw_en  = sw_q;
  assign iso_en = iso_q;
  assign ack    = ack_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_la_pwrseq.sv
// Directed self-checking bench for la_pwrseq (N=4, TIMEOUT=16).
module tb_la_pwrseq;

  logic       clk;
  logic       reset;
  logic       req;
  logic [7:0] stagedelay;
  logic       pwr_good;
  logic [3:0] sw_en;
  logic       iso_en;
  logic       ack;
  logic       busy;
  logic       err;

  int n_cmp;
  int n_bad;

  la_pwrseq #(
    .N       (4),
    .DW      (8),
    .TW      (12),
    .TIMEOUT (16),
    .PROP    ("DEFAULT")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .stagedelay (stagedelay),
    .pwr_good   (pwr_good),
    .sw_en      (sw_en),
    .iso_en     (iso_en),
    .ack        (ack),
    .busy       (busy),
    .err        (err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence.
  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req        = 1'b0;
    stagedelay = 8'd3;
    pwr_good   = 1'b1;

    tick(2);
    chk("rst_sw",   32'(sw_en), 32'h0);
    chk("rst_iso",  32'(iso_en), 32'h1);
    chk("rst_ack",  32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err",  32'(err), 32'h0);
    reset = 1'b0;
    tick(2);

    // Power-up, S=3, pwr_good high.
    req = 1'b1;
    tick(1);
    chk("up_t0_sw",   32'(sw_en), 32'h1);
    chk("up_t0_busy", 32'(busy), 32'h1);
    tick(2);
    chk("up_t2_sw", 32'(sw_en), 32'h1);
    tick(1);
    chk("up_t3_sw", 32'(sw_en), 32'h3);
    tick(3);
    chk("up_t6_sw", 32'(sw_en), 32'h7);
    tick(3);
    chk("up_t9_sw", 32'(sw_en), 32'hF);
    tick(3);
    chk("up_t12_iso", 32'(iso_en), 32'h1);
    chk("up_t12_ack", 32'(ack), 32'h0);
    tick(1);
    chk("up_t13_iso", 32'(iso_en), 32'h0);
    chk("up_t13_ack", 32'(ack), 32'h0);
    chk("up_t13_busy", 32'(busy), 32'h1);
    tick(1);
    chk("up_t14_ack", 32'(ack), 32'h1);
    chk("up_t14_busy", 32'(busy), 32'h0);
    chk("up_t14_sw", 32'(sw_en), 32'hF);

    // Power-down from ON.
    req = 1'b0;
    tick(1);
    chk("dn_e_iso",  32'(iso_en), 32'h1);
    chk("dn_e_ack",  32'(ack), 32'h0);
    chk("dn_e_busy", 32'(busy), 32'h1);
    chk("dn_e_sw",   32'(sw_en), 32'hF);
    tick(1);
    chk("dn_e1_sw", 32'(sw_en), 32'h7);
    tick(3);
    chk("dn_e4_sw", 32'(sw_en), 32'h3);
    tick(3);
    chk("dn_e7_sw", 32'(sw_en), 32'h1);
    tick(3);
    chk("dn_e10_sw",   32'(sw_en), 32'h0);
    chk("dn_e10_busy", 32'(busy), 32'h0);
    tick(2);

    // Abort during ramp-up.
    req = 1'b1;
    tick(1);
    chk("ab_t0_sw", 32'(sw_en), 32'h1);
    tick(3);
    chk("ab_t3_sw", 32'(sw_en), 32'h3);
    req = 1'b0;
    tick(1);
    chk("ab_t4_sw",  32'(sw_en), 32'h1);
    chk("ab_t4_iso", 32'(iso_en), 32'h1);
    chk("ab_t4_ack", 32'(ack), 32'h0);
    tick(2);
    chk("ab_t6_sw", 32'(sw_en), 32'h1);
    tick(1);
    chk("ab_t7_sw",   32'(sw_en), 32'h0);
    chk("ab_t7_busy", 32'(busy), 32'h0);
    chk("ab_t7_ack",  32'(ack), 32'h0);

    // Power-good timeout.
    pwr_good = 1'b0;
    tick(3);
    req = 1'b1;
    tick(1);
    chk("to_t0_sw", 32'(sw_en), 32'h1);
    tick(12);
    chk("to_t12_sw", 32'(sw_en), 32'hF);
    tick(15);
    chk("to_t27_err", 32'(err), 32'h0);
    tick(1);
    chk("to_t28_err", 32'(err), 32'h1);
    chk("to_t28_sw",  32'(sw_en), 32'h7);
    chk("to_t28_iso", 32'(iso_en), 32'h1);
    tick(3);
    chk("to_t31_sw", 32'(sw_en), 32'h3);
    tick(6);
    chk("to_t37_sw",   32'(sw_en), 32'h0);
    chk("to_t37_busy", 32'(busy), 32'h0);
    tick(5);
    chk("to_hold_sw",  32'(sw_en), 32'h0);
    chk("to_hold_err", 32'(err), 32'h1);
    chk("to_hold_ack", 32'(ack), 32'h0);
    req = 1'b0;
    tick(2);
    req = 1'b1;
    tick(1);
    chk("rt_t0_sw",  32'(sw_en), 32'h1);
    chk("rt_t0_err", 32'(err), 32'h0);
    tick(3);
    chk("rt_t3_sw", 32'(sw_en), 32'h3);

    // Asynchronous reset mid-ramp, between clock edges.
    #2;
    reset = 1'b1;
    #1;
    chk("ar_sw",   32'(sw_en), 32'h0);
    chk("ar_iso",  32'(iso_en), 32'h1);
    chk("ar_ack",  32'(ack), 32'h0);
    chk("ar_err",  32'(err), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);

    // stagedelay=0 spaces banks one cycle apart.
    pwr_good   = 1'b1;
    stagedelay = 8'd0;
    req        = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(3);
    req = 1'b1;
    tick(1);
    chk("z_t0_sw", 32'(sw_en), 32'h1);
    tick(1);
    chk("z_t1_sw", 32'(sw_en), 32'h3);
    tick(2);
    chk("z_t3_sw", 32'(sw_en), 32'hF);
    tick(2);
    chk("z_t5_iso", 32'(iso_en), 32'h0);
    tick(1);
    chk("z_t6_ack",  32'(ack), 32'h1);
    chk("z_t6_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/la_pwrseq.md
Name: la_pwrseq

Overview:
- Power-domain sequencer for one switchable Lambda domain.
- Turns on the domain's N header/decap switch banks in timed stages to limit inrush current, waits for the domain's power-good, then releases isolation and acknowledges.
- Power-down runs the reverse order.
- Sits in the always-on domain next to the auxlib power cells (headers, decaps, isolation cells) that it drives.

Parameters:
- N, 4, number of switch banks, N >= 1.
- DW, 8, width of stagedelay and of the stage counter.
- TW, 12, width of the power-good timeout counter.
- TIMEOUT, 1024, cycles allowed in WAIT_GOOD before fault; must fit in TW bits.
- PROP, "DEFAULT", technology/implementation property string, passed through.

Ports:
- clk  input  1  sequencer clock, always-on domain.
- reset  input  1  asynchronous active-high reset.
- req  input  1  level request: 1 = domain on, 0 = domain off.
- stagedelay  input  DW  cycles between bank steps; effective spacing S = max(stagedelay, 1).
- pwr_good  input  1  domain power-good; asynchronous, synchronized internally.
- sw_en  output  N  switch-bank enables, 1 = bank conducting.
- iso_en  output  1  isolation enable, 1 = domain outputs clamped.
- ack  output  1  1 = domain fully on and de-isolated.
- busy  output  1  1 whenever state is not OFF or ON.
- err  output  1  sticky power-good timeout fault.

Behaviour:
- Reset (async assert, sync deassert by the caller) sets: state=OFF, sw_en=0, iso_en=1, ack=0, err=0, counters=0, armed=1.
- States: OFF, RAMP_UP, WAIT_GOOD, DEISO, ON, ISO, RAMP_DOWN.
- pwr_good passes through a 2-flop synchronizer; pg_s is the synchronized value. It adds 2 cycles of latency.
- OFF:
  - If req=0, set armed<=1.
  - If req=1 and armed=1 at edge t0: sw_en[0]<=1, err<=0, armed<=0, stage counter<=S, state->RAMP_UP.
- RAMP_UP:
  - The counter decrements each cycle. Bank k turns on at edge t0+k*S.
  - S is re-sampled from stagedelay at each reload, so a mid-ramp change applies from the next step.
  - At edge t0+N*S: state->WAIT_GOOD, timeout counter<=TIMEOUT.
- WAIT_GOOD:
  - pg_s=1 at an edge: iso_en<=0, state->DEISO.
  - Timeout counter reaches 0 with pg_s still 0: err<=1, then enter RAMP_DOWN exactly as for a req drop.
- DEISO: next edge ack<=1, state->ON.
- ON:
  - req=0 at edge e: iso_en<=1, ack<=0, state->ISO.
  - A pg_s drop in ON is ignored; supply monitoring is out of scope.
- ISO: next edge clears the highest set bank of sw_en, loads counter<=S, state->RAMP_DOWN.
- RAMP_DOWN:
  - Every S cycles clear the highest remaining set bank.
  - At the edge that clears bank 0, state->OFF.
  - sw_en is always a thermometer code, and sw_en==0 iff state==OFF.
- Abort during RAMP_UP or WAIT_GOOD (req=0 at an edge):
  - At that same edge, clear the highest set bank, load counter<=S, state->RAMP_DOWN.
  - iso_en stays 1.
  - If the only set bank is bank 0, go directly to OFF.
- Abort in DEISO (req=0): iso_en<=1, state->ISO; ack never rises.
- req=1 during RAMP_DOWN or ISO: no effect; the sequence completes to OFF, and a new power-up needs req re-armed in OFF.
- After err, req must be seen low in OFF before a retry (the armed flag).
- Invariants:
  - iso_en=0 only in DEISO and ON.
  - ack=1 only in ON.
  - ack=1 implies sw_en all ones and iso_en=0.
- Counters saturate at 0; there is no wrap-around.
- Reset mid-operation drops every bank at once. This is acceptable because reset is only asserted with the domain supply intentionally collapsed.

Decomposition:
- Package la_pwrseq_pkg holds:
  - the state enum (3-bit, one-hot optional);
  - localparam helpers for the S = max(D, 1) computation.
- One sub-module: la_pwrseq_sync, a 2-flop synchronizer with an async active-high reset to 0, used for pwr_good.

Test Plan:
- Power-up, N=4, stagedelay=3, pwr_good tied 1:
  - sw_en = 0001 at t0, 0011 at t0+3, 0111 at t0+6, 1111 at t0+9.
  - WAIT_GOOD entered at t0+12 (state only).
  - iso_en falls at t0+13; ack rises at t0+14; busy=0 from t0+14.
- Power-down from ON, req falls at edge e:
  - iso_en=1 and ack=0 at e.
  - sw_en = 0111 at e+1, 0011 at e+4, 0001 at e+7, 0000 with state OFF at e+10.
- Abort: req drops 4 cycles after t0 (sw_en=0011):
  - same edge sw_en=0001, then 0000 three cycles later.
  - iso_en stays 1 and ack stays 0 throughout.
- Timeout: pwr_good held 0, TIMEOUT=16:
  - err=1 at WAIT_GOOD entry+16, followed by a normal ramp-down.
  - With req held 1, the block stays OFF.
  - req 0→1 restarts the ramp and clears err at t0.
- stagedelay=0: the ramp spaces banks 1 cycle apart, so sw_en is all ones by t0+3.
- Async reset asserted mid-RAMP_UP: sw_en=0, iso_en=1, ack=0, err=0 immediately, without waiting for a clock edge.
